// File: rtl/ay_pkg.sv
// Shared types and constants for the AY-3-8910 register bus master.
// The optional address cache is selected with the AY_ADDR_CACHE_EN macro.
package ay_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ASETUP,
        S_ASTB,
        S_AHOLD,
        S_DSETUP,
        S_DSTB,
        S_RWAIT,
        S_RECOV
    } ay_state_e;

    localparam logic [3:0] R_PERA_L = 4'd0;
    localparam logic [3:0] R_PERA_H = 4'd1;
    localparam logic [3:0] R_PERB_L = 4'd2;
    localparam logic [3:0] R_PERB_H = 4'd3;
    localparam logic [3:0] R_PERC_L = 4'd4;
    localparam logic [3:0] R_PERC_H = 4'd5;
    localparam logic [3:0] R_NOISE  = 4'd6;
    localparam logic [3:0] R_ENABLE = 4'd7;
    localparam logic [3:0] R_AMP_A  = 4'd8;
    localparam logic [3:0] R_AMP_B  = 4'd9;
    localparam logic [3:0] R_AMP_C  = 4'd10;
    localparam logic [3:0] R_ENV_L  = 4'd11;
    localparam logic [3:0] R_ENV_H  = 4'd12;
    localparam logic [3:0] R_SHAPE  = 4'd13;

    // Bus phase as {CS, BC, BDIR}
    typedef logic [2:0] ay_phase_t;
    localparam ay_phase_t PH_IDLE = 3'b000;
    localparam ay_phase_t PH_ADDR = 3'b110;
    localparam ay_phase_t PH_ASTB = 3'b111;
    localparam ay_phase_t PH_DATA = 3'b100;
    localparam ay_phase_t PH_DSTB = 3'b101;

    typedef struct packed {
        logic       write;
        logic [3:0] addr;
        logic [7:0] data;
    } ay_req_t;

    function automatic ay_phase_t phase_of(input ay_state_e s);
        case (s)
            S_ASETUP, S_AHOLD: return PH_ADDR;
            S_ASTB:            return PH_ASTB;
            S_DSETUP, S_RWAIT: return PH_DATA;
            S_DSTB:            return PH_DSTB;
            default:           return PH_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/ay_bus_master_fifo.sv
// Request FIFO: power-of-two depth, extra pointer bit distinguishes full from empty.
module ay_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 13
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr, rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push, do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    // A push into a full FIFO is dropped even if a pop frees a slot that cycle
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/ay_bus_master.sv
// AY-3-8910 register bus initiator: FIFO-buffered requests become address/data strobe sequences.
// Define AY_ADDR_CACHE_EN to skip the address phase when the register index is already latched.
module ay_bus_master
    import ay_pkg::*;
#(
    parameter int STROBE_CYCLES = 2,
    parameter int READ_WAIT     = 2,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic       REQ_WRITE,
    input  logic [3:0] REQ_ADDR,
    input  logic [7:0] REQ_DATA,
    output logic       RESP_VALID,
    output logic [7:0] RESP_DATA,
    output logic       BUSY,
    output logic       AY_CS,
    output logic       AY_BDIR,
    output logic       AY_BC,
    output logic [7:0] AY_DO,
    input  logic [7:0] AY_DI
);
    localparam int MAXC = (STROBE_CYCLES > READ_WAIT) ? STROBE_CYCLES : READ_WAIT;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] STB_LD = CW'(STROBE_CYCLES - 1);
    localparam logic [CW-1:0] RW_LD  = CW'(READ_WAIT - 1);

    ay_state_e     state, state_nx;
    logic [CW-1:0] cnt;
    ay_req_t       req_in, head, req_q, cur;
    logic          fifo_full, fifo_empty, push, pop, hit;

    assign req_in    = '{write: REQ_WRITE, addr: REQ_ADDR, data: REQ_DATA};
    assign REQ_READY = !fifo_full && !RESET;
    assign push      = REQ_VALID && REQ_READY;
    assign BUSY      = (state != S_IDLE) || !fifo_empty;
    assign {AY_CS, AY_BC, AY_BDIR} = phase_of(state);
    // In IDLE the request being popped is still at the FIFO head
    assign cur       = (state == S_IDLE) ? head : req_q;

    ay_req_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(ay_req_t))) u_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .push  (push),
        .wdata (req_in),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef AY_ADDR_CACHE_EN
    logic [3:0] cache_addr;
    logic       cache_vld;

    assign hit = cache_vld && (cache_addr == head.addr);

    // The PSG latches the index on the rising BDIR, i.e. on entry to ASTB
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cache_addr <= 4'h0;
            cache_vld  <= 1'b0;
        end else if (state == S_ASTB) begin
            cache_addr <= req_q.addr;
            cache_vld  <= 1'b1;
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (hit) state_nx = head.write ? S_DSETUP : S_RWAIT;
                    else     state_nx = S_ASETUP;
                end
            end
            S_ASETUP: state_nx = S_ASTB;
            S_ASTB:   if (cnt == '0) state_nx = S_AHOLD;
            S_AHOLD:  state_nx = req_q.write ? S_DSETUP : S_RWAIT;
            S_DSETUP: state_nx = S_DSTB;
            S_DSTB:   if (cnt == '0) state_nx = S_RECOV;
            S_RWAIT:  if (cnt == '0) state_nx = S_RECOV;
            S_RECOV:  state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= S_IDLE;
            cnt        <= '0;
            req_q      <= '0;
            AY_DO      <= 8'h00;
            RESP_VALID <= 1'b0;
            RESP_DATA  <= 8'h00;
        end else begin
            state      <= state_nx;
            RESP_VALID <= 1'b0;
            if (pop) req_q <= head;

            // Counters and bus data are loaded on state entry so they are stable for the whole phase
            if (state_nx != state) begin
                case (state_nx)
                    S_ASETUP: AY_DO <= {4'h0, cur.addr};
                    S_DSETUP: AY_DO <= cur.data;
                    S_RWAIT:  AY_DO <= 8'h00;
                    default: ;
                endcase
                case (state_nx)
                    S_ASTB, S_DSTB: cnt <= STB_LD;
                    S_RWAIT:        cnt <= RW_LD;
                    default:        cnt <= '0;
                endcase
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end

            if (state == S_RWAIT && cnt == '0) begin
                RESP_DATA  <= AY_DI;
                RESP_VALID <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ay_bus_master.sv
// Bench for ay_bus_master: PSG pin model plus an in-order register-file scoreboard.
module tb_ay_bus_master;
    import ay_pkg::*;

    localparam int S = 2;
    localparam int R = 2;
`ifdef AY_ADDR_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       REQ_VALID = 1'b0, REQ_WRITE = 1'b0;
    logic [3:0] REQ_ADDR = 4'h0;
    logic [7:0] REQ_DATA = 8'h00;
    logic       REQ_READY, RESP_VALID, BUSY, AY_CS, AY_BDIR, AY_BC;
    logic [7:0] RESP_DATA, AY_DO, AY_DI;

    always #5 CLK = ~CLK;

    ay_bus_master #(.STROBE_CYCLES(S), .READ_WAIT(R), .FIFO_DEPTH(4)) dut (
        .CLK(CLK), .RESET(RESET),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
        .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
        .RESP_VALID(RESP_VALID), .RESP_DATA(RESP_DATA), .BUSY(BUSY),
        .AY_CS(AY_CS), .AY_BDIR(AY_BDIR), .AY_BC(AY_BC), .AY_DO(AY_DO), .AY_DI(AY_DI)
    );

    // Behavioural PSG: index latched on rising BDIR with BC=1, data written on rising BDIR with BC=0
    logic [7:0] psg_reg [16] = '{default: 8'h00};
    logic [3:0] psg_addr = 4'h0;
    int         ast_cnt = 0, dst_cnt = 0;
    assign AY_DI = psg_reg[psg_addr];

    always @(posedge AY_BDIR) begin
        if (AY_BC) begin psg_addr = AY_DO[3:0]; ast_cnt++; end
        else       begin psg_reg[psg_addr] = AY_DO; dst_cnt++; end
    end

    int         n_cmp = 0, n_err = 0, cyc = 0;
    logic [7:0] gold [16];
    logic [7:0] rsp_q [$];
    int         exp_ast = 0, exp_dst = 0;
    logic [3:0] la = 4'h0;
    logic       lv = 1'b0;
    logic       p_bdir = 1'b0, p_bc = 1'b0, p_rv = 1'b0, rv_flag = 1'b0;
    logic [7:0] p_do = 8'h00, last_rsp = 8'h00;
    int         rv_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: sample at negedge and run the pin/response checks
    task automatic step();
        @(negedge CLK);
        cyc++;
        if (RESET) begin
            last_rsp = 8'h00;
        end else begin
            chk("bdir_without_cs", AY_BDIR & ~AY_CS, 1'b0);
            if (AY_BDIR && !p_bdir) begin
                chk("bc_setup", AY_BC, p_bc);
                chk("do_setup", AY_DO, p_do);
            end
            if (AY_BDIR && p_bdir) begin
                chk("bc_during_strobe", AY_BC, p_bc);
                chk("do_during_strobe", AY_DO, p_do);
            end
            if (!AY_BDIR && p_bdir) begin
                chk("bc_hold", AY_BC, p_bc);
                chk("do_hold", AY_DO, p_do);
            end
            if (RESP_VALID) begin
                chk("rv_single_cycle", p_rv, 1'b0);
                chk("rsp_expected", rsp_q.size() != 0, 1'b1);
                if (rsp_q.size() != 0) chk("rsp_data", RESP_DATA, rsp_q.pop_front());
                last_rsp = RESP_DATA;
                rv_flag  = 1'b1;
                rv_cyc   = cyc;
            end else begin
                chk("rsp_data_held", RESP_DATA, last_rsp);
            end
        end
        p_bdir = AY_BDIR; p_bc = AY_BC; p_do = AY_DO; p_rv = RESP_VALID;
    endtask

    // Offer one request; t = sample cycle in which it sits in the FIFO (the pop cycle when idle)
    task automatic push(input logic w, input logic [3:0] a, input logic [7:0] d,
                        output int t, output int waits);
        logic acc, hit;
        REQ_VALID = 1'b1; REQ_WRITE = w; REQ_ADDR = a; REQ_DATA = d;
        waits = 0;
        do begin
            acc = REQ_READY;
            step();
            if (!acc) waits++;
        end while (!acc && waits < 200);
        REQ_VALID = 1'b0;
        chk("push_accept", acc, 1'b1);
        t = cyc;
        if (acc) begin
            if (w) begin gold[a] = d; exp_dst++; end
            else   rsp_q.push_back(gold[a]);
            hit = CACHE && lv && (la == a);
            if (!hit) exp_ast++;
            la = a; lv = 1'b1;
        end
    endtask

    task automatic wait_idle(input int t0, output int dt);
        int n = 0;
        while (BUSY && n < 300) begin step(); n++; end
        chk("idle_timeout", BUSY, 1'b0);
        dt = cyc - t0;
    endtask

    task automatic wait_rv(input int t0, output int dt);
        int n = 0;
        while (!rv_flag && n < 300) begin step(); n++; end
        chk("rv_timeout", rv_flag, 1'b1);
        dt = rv_cyc - t0;
    endtask

    task automatic do_reset();
        RESET = 1'b1; REQ_VALID = 1'b0;
        step(); step();
        chk("rst_cs", AY_CS, 1'b0);
        chk("rst_bdir", AY_BDIR, 1'b0);
        chk("rst_bc", AY_BC, 1'b0);
        chk("rst_do", AY_DO, 8'h00);
        chk("rst_rv", RESP_VALID, 1'b0);
        chk("rst_rdata", RESP_DATA, 8'h00);
        chk("rst_busy", BUSY, 1'b0);
        RESET = 1'b0;
        step();
        chk("rst_ready", REQ_READY, 1'b1);
        lv = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t, w, dt, a0, d0, n;
        logic [7:0] g_snap [16];
        int a_snap, d_snap;
        logic wr;
        logic [3:0] ad;

        for (int i = 0; i < 16; i++) gold[i] = 8'h00;

        // 1: single write, full address + data phase
        do_reset();
        a0 = ast_cnt; d0 = dst_cnt;
        push(1'b1, R_ENABLE, 8'h38, t, w);
        wait_idle(t, dt);
        chk("t1_busy_latency", dt, 4 + 2*S + 1);
        chk("t1_addr_strobes", ast_cnt - a0, 1);
        chk("t1_data_strobes", dst_cnt - d0, 1);
        chk("t1_psg_index", psg_addr, R_ENABLE);
        chk("t1_psg_r7", psg_reg[R_ENABLE], 8'h38);

        // 2: write then read back the same register
        push(1'b1, R_PERA_L, 8'h5A, t, w);
        wait_idle(t, dt);
        d0 = dst_cnt; rv_flag = 1'b0;
        push(1'b0, R_PERA_L, 8'h00, t, w);
        wait_rv(t, dt);
        chk("t2_read_latency", dt, CACHE ? R + 1 : 3 + S + R);
        chk("t2_rdata", RESP_DATA, 8'h5A);
        wait_idle(t, dt);
        chk("t2_no_data_strobe", dst_cnt - d0, 0);

        // 3: burst of five behind a busy FSM, depth 4
        do_reset();
        push(1'b1, R_PERA_H, 8'h11, t, w);
        step(); step();
        push(1'b1, R_PERB_H, 8'hA1, t, w); chk("t3_imm0", w, 0);
        push(1'b1, R_PERB_H, 8'hA2, t, w); chk("t3_imm1", w, 0);
        push(1'b0, R_PERB_H, 8'h00, t, w); chk("t3_imm2", w, 0);
        push(1'b1, R_PERB_H, 8'hA4, t, w); chk("t3_imm3", w, 0);
        push(1'b0, R_PERB_H, 8'h00, t, w); chk("t3_fifth_stalled", w > 0, 1'b1);
        wait_idle(t, dt);
        chk("t3_rsp_drained", rsp_q.size(), 0);
        chk("t3_psg_r3", psg_reg[R_PERB_H], 8'hA4);

        // 4: reset during the data strobe aborts and flushes
        do_reset();
        g_snap = gold; a_snap = exp_ast; d_snap = exp_dst;
        push(1'b1, R_AMP_A, 8'h0F, t, w);
        push(1'b1, R_AMP_B, 8'h77, t, w);
        n = 0;
        while (!(AY_BDIR && !AY_BC) && n < 50) begin step(); n++; end
        chk("t4_reached_dstb", AY_BDIR & ~AY_BC, 1'b1);
        RESET = 1'b1;
        #1;
        chk("t4_cs", AY_CS, 1'b0);
        chk("t4_bdir", AY_BDIR, 1'b0);
        chk("t4_bc", AY_BC, 1'b0);
        chk("t4_do", AY_DO, 8'h00);
        chk("t4_busy_flushed", BUSY, 1'b0);
        gold = g_snap; gold[R_AMP_A] = 8'h0F;
        exp_ast = a_snap + 1; exp_dst = d_snap + 1;
        lv = 1'b0; rsp_q.delete();
        a0 = ast_cnt; d0 = dst_cnt;
        step(); step();
        RESET = 1'b0;
        repeat (20) step();
        chk("t4_no_addr_strobe", ast_cnt - a0, 0);
        chk("t4_no_data_strobe", dst_cnt - d0, 0);
        chk("t4_idle", BUSY, 1'b0);
        rv_flag = 1'b0;
        push(1'b0, R_AMP_B, 8'h00, t, w);
        wait_rv(t, dt);
        wait_idle(t, dt);

        // 5: repeated register index, then reset invalidates the cache
        do_reset();
        a0 = ast_cnt;
        push(1'b1, R_SHAPE, 8'h01, t, w);
        push(1'b1, R_SHAPE, 8'h08, t, w);
        wait_idle(t, dt);
        chk("t5_addr_phases", ast_cnt - a0, CACHE ? 1 : 2);
        chk("t5_psg_r13", psg_reg[R_SHAPE], 8'h08);
        do_reset();
        a0 = ast_cnt;
        push(1'b1, R_SHAPE, 8'h03, t, w);
        wait_idle(t, dt);
        chk("t5_addr_after_reset", ast_cnt - a0, 1);

        // 6: read of an all-ones register, single-cycle response
        push(1'b1, 4'd14, 8'hFF, t, w);
        wait_idle(t, dt);
        rv_flag = 1'b0;
        push(1'b0, 4'd14, 8'h00, t, w);
        wait_rv(t, dt);
        chk("t6_rdata", RESP_DATA, 8'hFF);
        step();
        chk("t6_rv_dropped", RESP_VALID, 1'b0);
        chk("t6_rdata_held", RESP_DATA, 8'hFF);
        wait_idle(t, dt);

        // Random traffic against the in-order register-file model
        for (int i = 0; i < 80; i++) begin
            wr = 1'($urandom_range(0, 1));
            ad = 4'($urandom_range(0, 15));
            push(wr, ad, 8'($urandom), t, w);
            repeat ($urandom_range(0, 2)) step();
        end
        wait_idle(t, dt);
        repeat (3) step();
        chk("rand_rsp_drained", rsp_q.size(), 0);
        for (int i = 0; i < 16; i++) chk($sformatf("psg_r%0d", i), psg_reg[i], gold[i]);
        chk("total_addr_strobes", ast_cnt, exp_ast);
        chk("total_data_strobes", dst_cnt, exp_dst);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
